// File: rtl/systolic_feeder_pkg.sv
// Shared sizing, state encoding and vector types for the systolic array feeder.
package systolic_pkg;
    localparam int N         = 4;
    localparam int DW        = 16;
    localparam int CW        = 2 * DW + 1;
    localparam int DRAIN     = 2;
    localparam int AW        = $clog2(N * N);
    localparam int FEED_LAST = 3 * N - 3;
    // The step counter is shared by FEED and DRAIN, so it must hold the larger limit.
    localparam int SW        = $clog2(((FEED_LAST > DRAIN) ? FEED_LAST : DRAIN) + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_e;

    typedef logic [N-1:0][DW-1:0] vec_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// Load port, run control and skewed operand outputs of the systolic feeder.
interface systolic_feeder_if;
    import systolic_pkg::*;

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    vec_t          a_out;
    vec_t          b_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, a_out, b_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, a_out, b_out
    );
endinterface

// File: rtl/systolic_feeder_mat_buf.sv
// NxN operand register file with a skewed wavefront read (row-major for A, column for B).
module feeder_mat_buf
    import systolic_pkg::*;
#(
    parameter bit COL_MODE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [SW-1:0] step_i,
    output vec_t          rd_o
);
    logic [N*N-1:0][DW-1:0] mem_q;
    logic                   addr_ok;

    generate
        if (N * N == (1 << AW)) begin : g_full
            assign addr_ok = 1'b1;
        end else begin : g_part
            assign addr_ok = ({1'b0, wr_addr_i} < (AW + 1)'(N * N));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (wr_en_i && addr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A write landing on the same edge as the read is forwarded, so a load
    // issued together with start is seen by the very first wavefront.
    always_comb begin
        int            k;
        logic [AW-1:0] idx;
        rd_o = '0;
        k    = 0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            k   = int'(step_i) - i;
            idx = '0;
            if (k >= 0 && k < N) begin
                idx     = COL_MODE ? AW'(k * N + i) : AW'(i * N + k);
                rd_o[i] = (wr_en_i && addr_ok && wr_addr_i == idx) ? wr_data_i : mem_q[idx];
            end
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A rows / B columns into a 4x4 systolic array, then drains and pulses done.
// Optional SYSTOLIC_FEEDER_PERF_EN adds a perf_cycles run-length counter output.
module systolic_feeder
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);
    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    vec_t          a_q, a_d, b_q, b_d;
    vec_t          a_rd, b_rd;
    logic          open, wr_ok, go;

    assign open  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wr_ok = bus.wr_en && open;
    assign go    = bus.start && open;

    // Buffers are read at the next step so the registered outputs line up with it.
    feeder_mat_buf #(.COL_MODE(1'b0)) u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok && !bus.wr_sel),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .step_i    (step_d),
        .rd_o      (a_rd)
    );

    feeder_mat_buf #(.COL_MODE(1'b1)) u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok && bus.wr_sel),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .step_i    (step_d),
        .rd_o      (b_rd)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_FEED;
                    step_d  = '0;
                end
            end
            ST_FEED: begin
                if (step_q == SW'(FEED_LAST)) begin
                    state_d = ST_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (step_q == SW'(DRAIN - 1)) begin
                    state_d = ST_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                step_d  = '0;
                state_d = go ? ST_FEED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
        busy_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        a_d    = (state_d == ST_FEED) ? a_rd : '0;
        b_d    = (state_d == ST_FEED) ? b_rd : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.a_out = a_q;
    assign bus.b_out = b_q;

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] pcnt_q, pcnt_d, perf_q, perf_d;

    // The accept edge counts as cycle 1, so a default run reports 13.
    always_comb begin
        pcnt_d = pcnt_q;
        perf_d = perf_q;
        if (go) begin
            pcnt_d = 16'd1;
        end else if (state_q != ST_IDLE && pcnt_q != 16'hFFFF) begin
            pcnt_d = pcnt_q + 16'd1;
        end
        if (state_d == ST_DONE) begin
            perf_d = pcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
            perf_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Checks the feeder against a cycle-indexed model of the run schedule plus directed scenarios.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int TDONE = 3 * N - 1 + DRAIN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if bus ();
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] perf;
`endif

    systolic_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SYSTOLIC_FEEDER_PERF_EN
        ,
        .perf_cycles (perf)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: t = cycles since start was accepted (0 = idle, TDONE = done cycle).
    logic [DW-1:0] mA [N*N];
    logic [DW-1:0] mB [N*N];
    int            t;

    function automatic bit model_open();
        return (t == 0) || (t == TDONE);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (mA[k]) begin
                mA[k] <= '0;
                mB[k] <= '0;
            end
            t <= 0;
        end else begin
            if (bus.wr_en && model_open() && int'(bus.wr_addr) < N * N) begin
                if (bus.wr_sel) mB[bus.wr_addr] <= bus.wr_data;
                else            mA[bus.wr_addr] <= bus.wr_data;
            end
            if (model_open() && bus.start) t <= 1;
            else if (t == TDONE)           t <= 0;
            else if (t > 0)                t <= t + 1;
        end
    end

    function automatic vec_t exp_vec(input bit is_b);
        vec_t v;
        int   s;
        v = '0;
        s = t - 1;
        if (t >= 1 && t <= 3 * N - 2) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = s - i;
                if (k >= 0 && k < N) v[i] = is_b ? mB[k * N + i] : mA[i * N + k];
            end
        end
        return v;
    endfunction

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b1 && chk_on) begin
            chk("busy",  64'(bus.busy),  64'(t >= 1 && t < TDONE));
            chk("done",  64'(bus.done),  64'(t == TDONE));
            chk("a_out", 64'(bus.a_out), 64'(exp_vec(1'b0)));
            chk("b_out", 64'(bus.b_out), 64'(exp_vec(1'b1)));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    int gA [N*N];
    int gB [N*N];
    vec_t cap_a [0:31];
    vec_t cap_b [0:31];

    task automatic wr(input bit sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = AW'(addr);
        bus.wr_data = DW'(data);
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_g();
        for (int a = 0; a < N * N; a++) begin
            wr(1'b0, a, gA[a]);
            wr(1'b1, a, gB[a]);
        end
    endtask

    task automatic run_capture(output int done_at);
        done_at   = -1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            cap_a[c] = bus.a_out;
            cap_b[c] = bus.b_out;
            if (bus.done) begin
                done_at = c;
                break;
            end
            cyc();
        end
    endtask

    // Rebuild C from the captured streams the way the PE grid would combine them.
    task automatic chk_product(input string nm);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int acc, gold;
                acc  = 0;
                gold = 0;
                for (int k = 0; k < N; k++) begin
                    acc  += int'(cap_a[i + k + 1][i]) * int'(cap_b[j + k + 1][j]);
                    gold += gA[i * N + k] * gB[k * N + j];
                end
                chk(nm, 64'(acc), 64'(gold));
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            cyc();
            if (bus.done) n++;
        end
    endtask

    initial begin
        int   d, nd, sum;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        repeat (2) cyc();
        chk("rst_busy", 64'(bus.busy),  64'(0));
        chk("rst_done", 64'(bus.done),  64'(0));
        chk("rst_a",    64'(bus.a_out), 64'(0));
        chk("rst_b",    64'(bus.b_out), 64'(0));
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("rst_perf", 64'(perf), 64'(0));
`endif
        rst = 1'b1;
        cyc();
        chk_on = 1'b1;

        // Identity A, B all 5.
        for (int a = 0; a < N * N; a++) begin
            gA[a] = (a / N == a % N) ? 1 : 0;
            gB[a] = 5;
        end
        load_g();
        run_capture(d);
        chk("t1_latency", 64'(d), 64'(13));
        chk("t1_a1_s0",   64'(cap_a[1][0]), 64'(1));
        chk("t1_a4_s6",   64'(cap_a[7][3]), 64'(1));
        chk("t1_a4_s5",   64'(cap_a[6][3]), 64'(0));
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("t1_perf", 64'(perf), 64'(13));
`endif
        chk_product("t1_prod");
        cyc();

        // A[i][k]=i+k+1, B[k][j]=k*j+1.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                gA[r * N + c] = r + c + 1;
                gB[r * N + c] = r * c + 1;
            end
        load_g();
        run_capture(d);
        chk("t2_latency", 64'(d), 64'(13));
        chk("t2_a1_s3",   64'(cap_a[4][0]), 64'(4));
        chk("t2_b2_s2",   64'(cap_b[3][1]), 64'(2));
        chk("t2_b4_s0",   64'(cap_b[1][3]), 64'(0));
        chk("t2_a1_s9",   64'(cap_a[10][0]), 64'(0));
        chk_product("t2_prod");
        cyc();

        // Write while busy is dropped; start while busy is ignored.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (3) cyc();
        wr(1'b0, 0, 16'hFFFF);
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        count_done(25, nd);
        chk("t3_one_done", 64'(nd), 64'(1));
        run_capture(d);
        chk("t3_wr_drop", 64'(cap_a[1][0]), 64'(1));
        cyc();

        // Start in the DONE cycle gives a back-to-back run.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        nd = 0;
        for (int c = 0; c < 30 && !bus.done; c++) cyc();
        chk("t4_first_done", 64'(bus.done), 64'(1));
        if (bus.done) nd = 1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("t4_b2b_busy", 64'(bus.busy), 64'(1));
        chk("t4_b2b_a0",   64'(bus.a_out[0]), 64'(1));
        count_done(30, d);
        chk("t4_two_done", 64'(nd + d), 64'(2));

        // Asynchronous abort at FEED step 4.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (4) cyc();
        #2 rst = 1'b0;
        #1;
        chk("t5_a_zero", 64'(bus.a_out), 64'(0));
        chk("t5_b_zero", 64'(bus.b_out), 64'(0));
        chk("t5_busy0",  64'(bus.busy),  64'(0));
        cyc();
        rst = 1'b1;
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("t5_perf0", 64'(perf), 64'(0));
`endif
        count_done(20, nd);
        chk("t5_no_done", 64'(nd), 64'(0));
        run_capture(d);
        sum = 0;
        for (int c = 1; c <= 13; c++)
            for (int i = 0; i < N; i++) sum += int'(cap_a[c][i]) + int'(cap_b[c][i]);
        chk("t5_buf_clear", 64'(sum), 64'(0));
        cyc();

        // Randomized traffic against the model, including occasional aborts.
        for (int n = 0; n < 600; n++) begin
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_sel  = 1'($urandom_range(0, 1));
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
            bus.start   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                #1;
                chk("rnd_abort_busy", 64'(bus.busy),  64'(0));
                chk("rnd_abort_a",    64'(bus.a_out), 64'(0));
                cyc();
                rst = 1'b1;
            end else begin
                cyc();
            end
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
